// File: rtl/addsub_pipe.sv
// addsub_pipe: pipelined two's-complement add/sub with the carry chain split
// into registered segments, optional halving, overflow flag and saturation.
module addsub_pipe #(
    parameter int WIDTH = 16,
    parameter int SEG   = 4,
    parameter bit SAT   = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    input  logic             in_scale,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_ovf
);
    localparam int NSEG = WIDTH / SEG;

    logic             advance;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_ovf_q, out_ovf_d;

    assign advance  = ~out_valid_q | out_ready;
    assign in_ready = advance;

    // w_q carries finished sum segments below the current one and the
    // untouched operand a above it, so one vector serves both roles.
    for (genvar j = 0; j < NSEG; j++) begin : g_st
        logic [WIDTH-1:0] a_in, bx_in, w_d, w_q, bx_q;
        logic             cin, scl_in, vld_in, c_d;
        logic             c_q, scl_q, vld_q;
        logic [SEG:0]     sum;

        if (j == 0) begin : g_head
            assign a_in   = in_a;
            assign bx_in  = in_b ^ {WIDTH{in_sub}};
            assign cin    = in_sub;
            assign scl_in = in_scale;
            assign vld_in = in_valid;
        end else begin : g_body
            assign a_in   = g_st[j-1].w_q;
            assign bx_in  = g_st[j-1].bx_q;
            assign cin    = g_st[j-1].c_q;
            assign scl_in = g_st[j-1].scl_q;
            assign vld_in = g_st[j-1].vld_q;
        end

        assign sum = {1'b0, a_in[j*SEG +: SEG]}
                   + {1'b0, bx_in[j*SEG +: SEG]}
                   + {{SEG{1'b0}}, cin};

        always_comb begin
            w_d = a_in;
            w_d[j*SEG +: SEG] = sum[SEG-1:0];
        end

        // The last stage stores the sign-extension bit r[WIDTH] in c_q.
        if (j == NSEG - 1) begin : g_last
            logic unused_bx;
            assign c_d       = a_in[WIDTH-1] ^ bx_in[WIDTH-1] ^ sum[SEG];
            assign unused_bx = ^bx_q;
        end else begin : g_mid
            logic unused_bx;
            assign c_d       = sum[SEG];
            assign unused_bx = ^bx_q[(j+1)*SEG-1:0];
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                vld_q <= 1'b0;
            end else if (advance) begin
                vld_q <= vld_in;
            end
        end

        always_ff @(posedge clk) begin
            if (advance) begin
                w_q   <= w_d;
                bx_q  <= bx_in;
                c_q   <= c_d;
                scl_q <= scl_in;
            end
        end
    end

    logic [WIDTH:0] r;
    logic           ovf_raw;
    logic           last_scl, last_vld;

    assign r        = {g_st[NSEG-1].c_q, g_st[NSEG-1].w_q};
    assign last_scl = g_st[NSEG-1].scl_q;
    assign last_vld = g_st[NSEG-1].vld_q;
    assign ovf_raw  = r[WIDTH] ^ r[WIDTH-1];

    always_comb begin
        out_data_d = r[WIDTH-1:0];
        out_ovf_d  = 1'b0;
        if (last_scl) begin
            out_data_d = r[WIDTH:1];
        end else if (ovf_raw) begin
            out_ovf_d = 1'b1;
            if (SAT) begin
                out_data_d = r[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}}
                                      : {1'b0, {(WIDTH-1){1'b1}}};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ovf_q   <= 1'b0;
        end else if (advance) begin
            out_valid_q <= last_vld;
            out_data_q  <= out_data_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ovf   = out_ovf_q;
endmodule

// File: tb/tb_addsub_pipe.sv
// Bench for addsub_pipe: saturating and wrapping instances share one input
// stream; a forked monitor scoreboards both outputs against queued results.
`timescale 1ns/1ps
module tb_addsub_pipe;
    localparam int W    = 16;
    localparam int NSEG = 4;

    typedef struct {
        logic [W-1:0] d;
        logic         o;
        int           acc;
        bit           lat;
    } exp_t;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic         scl;
        logic [W-1:0] d1;
        logic         o1;
        logic [W-1:0] d0;
        logic         o0;
    } vec_t;

    // a, b, sub, scale, SAT=1 result/ovf, SAT=0 result/ovf
    localparam vec_t VEC [13] = '{
        '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h7FFF, 1'b1, 16'h8000, 1'b1},
        '{16'h8000, 16'h0001, 1'b1, 1'b0, 16'h8000, 1'b1, 16'h7FFF, 1'b1},
        '{16'h1234, 16'h0234, 1'b1, 1'b0, 16'h1000, 1'b0, 16'h1000, 1'b0},
        '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0},
        '{16'h7FFF, 16'h7FFF, 1'b0, 1'b1, 16'h7FFF, 1'b0, 16'h7FFF, 1'b0},
        '{16'h8000, 16'h8000, 1'b0, 1'b1, 16'h8000, 1'b0, 16'h8000, 1'b0},
        '{16'hFFFF, 16'h0000, 1'b0, 1'b1, 16'hFFFF, 1'b0, 16'hFFFF, 1'b0},
        '{16'h0003, 16'h0000, 1'b1, 1'b1, 16'h0001, 1'b0, 16'h0001, 1'b0},
        '{16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 16'hFFFE, 1'b0},
        '{16'h0001, 16'h0004, 1'b1, 1'b1, 16'hFFFE, 1'b0, 16'hFFFE, 1'b0},
        '{16'h8000, 16'hFFFF, 1'b0, 1'b0, 16'h8000, 1'b1, 16'h7FFF, 1'b1},
        '{16'h7FFF, 16'hFFFF, 1'b1, 1'b0, 16'h7FFF, 1'b1, 16'h8000, 1'b1},
        '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 16'h0100, 1'b0}
    };

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_sub = 1'b0;
    logic         in_scale = 1'b0;
    logic         out_ready = 1'b1;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic         ir1, ov1, oo1, ir0, ov0, oo0;
    logic [W-1:0] od1, od0;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   mode = 0;
    bit   mon_en = 1'b0;
    exp_t q1[$];
    exp_t q0[$];

    addsub_pipe #(.WIDTH(W), .SEG(4), .SAT(1'b1)) dut_sat (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(ir1),
        .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_scale(in_scale),
        .out_valid(ov1), .out_ready(out_ready),
        .out_data(od1), .out_ovf(oo1)
    );

    addsub_pipe #(.WIDTH(W), .SEG(4), .SAT(1'b0)) dut_wrap (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(ir0),
        .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_scale(in_scale),
        .out_valid(ov0), .out_ready(out_ready),
        .out_data(od0), .out_ovf(oo0)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkb(input string nm, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %b want %b", nm, got, want);
        end
    endtask

    task automatic check16(input string nm, input logic [W-1:0] got,
                           input logic [W-1:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic sub, input logic scl,
                                  output logic [W-1:0] d1, output logic o1,
                                  output logic [W-1:0] d0, output logic o0);
        int r;
        r = sub ? int'($signed(a)) - int'($signed(b))
                : int'($signed(a)) + int'($signed(b));
        o1 = 1'b0;
        o0 = 1'b0;
        if (scl) r = r >>> 1;
        d0 = r[W-1:0];
        d1 = d0;
        if (!scl && (r > 32767 || r < -32768)) begin
            o1 = 1'b1;
            o0 = 1'b1;
            d1 = (r > 0) ? 16'h7FFF : 16'h8000;
        end
    endfunction

    task automatic push(input logic [W-1:0] e1, input logic o1,
                        input logic [W-1:0] e0, input logic o0, input bit lat);
        exp_t e;
        e.acc = cyc + 1;
        e.lat = lat;
        e.d = e1;
        e.o = o1;
        q1.push_back(e);
        e.d = e0;
        e.o = o0;
        q0.push_back(e);
    endtask

    task automatic cmp(input string nm, input logic [W-1:0] d, input logic o,
                       input exp_t e);
        checks++;
        if (d !== e.d || o !== e.o) begin
            failures++;
            $display("FAIL %s: got data=%h ovf=%b want data=%h ovf=%b",
                     nm, d, o, e.d, e.o);
        end
        if (e.lat) begin
            checks++;
            if (cyc - e.acc != NSEG) begin
                failures++;
                $display("FAIL %s_latency: got %0d edges want %0d",
                         nm, cyc - e.acc + 1, NSEG + 1);
            end
        end
    endtask

    task automatic monitor();
        bit           st1 = 1'b0;
        bit           st0 = 1'b0;
        logic [W-1:0] pd1 = '0;
        logic [W-1:0] pd0 = '0;
        logic         po1 = 1'b0;
        logic         po0 = 1'b0;
        exp_t         e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                checkb("in_ready_match", ir0, ir1);
                if (st1) begin
                    checks++;
                    if (ov1 !== 1'b1 || od1 !== pd1 || oo1 !== po1) begin
                        failures++;
                        $display("FAIL stall_hold_sat: got v=%b d=%h o=%b want v=1 d=%h o=%b",
                                 ov1, od1, oo1, pd1, po1);
                    end
                end
                if (st0) begin
                    checks++;
                    if (ov0 !== 1'b1 || od0 !== pd0 || oo0 !== po0) begin
                        failures++;
                        $display("FAIL stall_hold_wrap: got v=%b d=%h o=%b want v=1 d=%h o=%b",
                                 ov0, od0, oo0, pd0, po0);
                    end
                end
                if (ov1 === 1'b1 && out_ready === 1'b1) begin
                    if (q1.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_sat: got data=%h want no output", od1);
                    end else begin
                        e = q1.pop_front();
                        cmp("result_sat", od1, oo1, e);
                    end
                end
                if (ov0 === 1'b1 && out_ready === 1'b1) begin
                    if (q0.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_wrap: got data=%h want no output", od0);
                    end else begin
                        e = q0.pop_front();
                        cmp("result_wrap", od0, oo0, e);
                    end
                end
                st1 = (ov1 === 1'b1) && (out_ready === 1'b0);
                st0 = (ov0 === 1'b1) && (out_ready === 1'b0);
                pd1 = od1;
                po1 = oo1;
                pd0 = od0;
                po0 = oo0;
            end
        end
    endtask

    task automatic ready_drv();
        forever begin
            @(posedge clk);
            #1;
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'b0;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    endtask

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic sub, input logic scl,
                         input logic [W-1:0] e1, input logic o1,
                         input logic [W-1:0] e0, input logic o0, input bit lat);
        int guard;
        guard = 0;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_sub = sub;
        in_scale = scl;
        @(negedge clk);
        while (ir1 !== 1'b1 && guard < 500) begin
            guard++;
            @(negedge clk);
        end
        if (ir1 !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: in_ready=%b want 1", ir1);
        end else begin
            push(e1, o1, e0, o0, lat);
        end
        @(posedge clk);
        #2;
        in_valid = 1'b0;
    endtask

    task automatic issue_rand();
        logic [W-1:0] a, b, d1, d0;
        logic         s, c, o1, o0;
        a = 16'($urandom);
        b = 16'($urandom);
        s = 1'($urandom_range(0, 1));
        c = ($urandom_range(0, 3) == 0);
        model(a, b, s, c, d1, o1, d0, o0);
        issue(a, b, s, c, d1, o1, d0, o0, 1'b0);
    endtask

    task automatic wait_drain();
        int g;
        g = 0;
        while ((q1.size() != 0 || q0.size() != 0) && g < 2000) begin
            @(negedge clk);
            g++;
        end
        checks++;
        if (q1.size() != 0 || q0.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d/%0d results outstanding want 0",
                     q1.size(), q0.size());
            q1.delete();
            q0.delete();
        end
        @(posedge clk);
        #2;
    endtask

    initial begin
        int           acc_n;
        int           start;
        logic [W-1:0] a, b, d1, d0;
        logic         s, c, o1, o0;

        fork
            monitor();
            ready_drv();
        join_none

        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        checkb("rst_valid_sat", ov1, 1'b0);
        checkb("rst_valid_wrap", ov0, 1'b0);
        check16("rst_data_sat", od1, 16'h0000);
        check16("rst_data_wrap", od0, 16'h0000);
        checkb("rst_ovf_sat", oo1, 1'b0);
        checkb("rst_ovf_wrap", oo0, 1'b0);
        checkb("rst_in_ready", ir1, 1'b1);
        mon_en = 1'b1;
        @(posedge clk);
        #2;

        for (int i = 0; i < 13; i++) begin
            issue(VEC[i].a, VEC[i].b, VEC[i].sub, VEC[i].scl,
                  VEC[i].d1, VEC[i].o1, VEC[i].d0, VEC[i].o0, i == 0);
        end
        wait_drain();

        start = cyc;
        for (int i = 0; i < 1000; i++) issue_rand();
        check16("stream_cycles", 16'(cyc - start), 16'd1000);
        wait_drain();

        mode = 2;
        for (int i = 0; i < 500; i++) issue_rand();
        mode = 0;
        wait_drain();

        mode = 1;
        @(posedge clk);
        #2;
        acc_n = 0;
        for (int i = 0; i < 10; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            s = 1'($urandom_range(0, 1));
            c = 1'b0;
            model(a, b, s, c, d1, o1, d0, o0);
            in_valid = 1'b1;
            in_a = a;
            in_b = b;
            in_sub = s;
            in_scale = c;
            @(negedge clk);
            if (ir1 === 1'b1) begin
                push(d1, o1, d0, o0, 1'b0);
                acc_n++;
            end
            @(posedge clk);
            #2;
        end
        @(negedge clk);
        checkb("bp_in_ready_low", ir1, 1'b0);
        in_valid = 1'b0;
        check16("bp_accepted", 16'(acc_n), 16'(NSEG + 1));
        mode = 0;
        @(posedge clk);
        #2;
        wait_drain();

        for (int i = 0; i < 3; i++) issue_rand();
        rst = 1'b1;
        in_valid = 1'b1;
        in_a = 16'h1111;
        in_b = 16'h2222;
        in_sub = 1'b0;
        in_scale = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b0;
        in_valid = 1'b0;
        q1.delete();
        q0.delete();
        @(negedge clk);
        checkb("midrst_valid_sat", ov1, 1'b0);
        checkb("midrst_valid_wrap", ov0, 1'b0);
        checkb("midrst_in_ready", ir1, 1'b1);
        @(posedge clk);
        #2;
        issue(VEC[2].a, VEC[2].b, VEC[2].sub, VEC[2].scl,
              VEC[2].d1, VEC[2].o1, VEC[2].d0, VEC[2].o0, 1'b1);
        wait_drain();
        repeat (12) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
